mem_wb_stage: RTL
=================

# mem_wb_stage

Parametrised MEM-to-WB pipeline stage of the MIPS core. It accepts the instruction in MEM, waits on the data-SRAM response for loads and stores, and aligns and extends load data. It registers the result toward WB under a valid/allowin handshake, and it discards an orphaned memory response after a flush. It supersedes the fixed, always-enabled MEM register with stall-aware, flush-safe behaviour.

## Interface
- `REG_AW`, 5, register-file address width.
- `MMOP_W`, 4, memop field width; encoding: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LWL, 10 LWR, others none.
- `clk  in  1`  rising-edge clock.
- `rst_n  in  1`  reset, asynchronous, active-low.
- `mem_valid_i  in  1`  MEM slot holds an instruction.
- `mem_inst_i  in  32`  instruction word.
- `mem_inslot_i  in  1`  instruction is in a delay slot.
- `mem_memop_i  in  MMOP_W`  memory operation.
- `mem_addr_lo_i  in  2`  effective address [1:0].
- `mem_waddr_i  in  REG_AW`  destination register.
- `mem_wdata_i  in  32`  ALU result; old rt value for LWL/LWR.
- `mem_wren_i  in  1`  register write enable.
- `mem_flush_i  in  1`  kill the MEM-slot instruction.
- `dram_data_ok_i  in  1`  one-cycle SRAM response (load data or store ack).
- `dram_rdata_i  in  32`  load data, valid with `dram_data_ok_i`.
- `wb_allowin_i  in  1`  WB accepts this cycle.
- `mem_stall_o  out  1`  MEM must hold its inputs (combinational).
- `wb_valid_o`, `wb_inst_o`, `wb_inslot_o`, `wb_waddr_o`, `wb_wdata_o`, `wb_wren_o`  out  1/32/1/REG_AW/32/1  registered WB-side outputs.

## Operation
- Memory op = memop 1..10. Non-memory ops are ready immediately.
- Control FSM:
  - IDLE: no pending response.
  - WAIT: memory op in MEM, no response yet.
  - BUF: response captured in `rbuf`, output blocked.
  - DISCARD: flushed op whose response is still due.
- IDLE→WAIT: a valid memory op is in MEM and `dram_data_ok_i`=0.
- WAIT→BUF: `dram_data_ok_i`=1 but the output cannot accept.
- WAIT→IDLE and BUF→IDLE: the result is transferred.
- ready = non-memory op, or `dram_data_ok_i`, or state BUF. Load data source is `rbuf` in BUF, otherwise `dram_rdata_i`.
- Output accepts when `!wb_valid_o || wb_allowin_i`. Transfer = `mem_valid_i && !mem_flush_i && ready && accept`.
- `mem_stall_o` = `mem_valid_i && !mem_flush_i && !(ready && accept)`.
- Load extraction by `mem_addr_lo_i`:
  - LB/LBU select byte [8*a+7:8*a], then sign-/zero-extend.
  - LH/LHU select half [16*a[1]+15:16*a[1]] (a[0] ignored), then sign-/zero-extend.
  - LW passes the word through.
  - Stores and non-memory ops forward `mem_wdata_i`.
- Flush:
  - In WAIT with no same-cycle response → DISCARD; the next `dram_data_ok_i` is dropped, then → IDLE.
  - In WAIT with a same-cycle response, or in BUF → IDLE; the data is dropped.
- In DISCARD, `mem_stall_o`=1 for any valid memory op in MEM. A non-memory op may still transfer.
- WB output: `wb_valid_o` clears on `wb_allowin_i` when no new transfer occurs. Payload registers change only on transfer.

## Timing
- Reset: state IDLE, `rbuf`=0. All `wb_*` outputs are 0. `mem_stall_o` follows its equation; it is 0 with inputs idle.
- Latency: a result appears on `wb_*` the cycle after transfer. A same-cycle `dram_data_ok_i` gives a zero-stall load.
- `mem_stall_o` has a combinational path from `dram_data_ok_i`, `wb_allowin_i` and `mem_flush_i`. Outputs are registered.
- A response and a flush in the same cycle: the flush wins, with no DISCARD.
- Reset during WAIT/DISCARD → IDLE. A response after reset is ignored, because the state is IDLE and the op is not valid.
- At most one outstanding response; the block never accepts a second.

## Configuration
- `MEM_WB_LWLR_EN` defined: memop 9/10 are memory ops and merge SRAM data with `mem_wdata_i`:
  - LWL a=0,1,2,3 → {rd[7:0],rt[23:0]}, {rd[15:0],rt[15:0]}, {rd[23:0],rt[7:0]}, rd.
  - LWR a=0,1,2,3 → rd, {rt[31:24],rd[31:8]}, {rt[31:16],rd[31:16]}, {rt[31:8],rd[31:24]}.
- Undefined: memop 9/10 are treated as none and forward `mem_wdata_i` without waiting.

## Test plan
- LB, a=3, rdata 0x80FF_1234, `dram_data_ok_i` same cycle, allowin=1 → no stall; next cycle `wb_wdata_o`=0xFFFF_FF80, `wb_valid_o`=1.
- LHU, a=2, response after 3 cycles → `mem_stall_o`=1 for 3 cycles; `wb_wdata_o`=0x0000_80FF.
- LW, data arrives while `wb_allowin_i`=0 → state BUF, stall held; allowin=1 → the buffered word is transferred.
- LW, flush in WAIT, `dram_data_ok_i` 2 cycles later, then ADD in MEM → the stale data is dropped; ADD's `mem_wdata_i` appears on WB.
- SW, ack in cycle 1 → stall in cycle 0 only; `wb_wren_o` follows `mem_wren_i`=0.
- With `MEM_WB_LWLR_EN`: LWL, a=1, rd=0xAABB_CCDD, rt=0x1122_3344 → 0xCCDD_3344. Without it → 0x1122_3344, no stall.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-slot, data-SRAM response and WB-side signals of the MEM-to-WB stage
//   master: drives the MEM slot, SRAM response and wb_allowin; sees stall and the WB registers
//   slave : the stage itself
interface mem_wb_stage_if #(parameter int REG_AW = 5, parameter int MMOP_W = 4);
  logic              mem_valid;
  logic [31:0]       mem_inst;
  logic              mem_inslot;
  logic [MMOP_W-1:0] mem_memop;
  logic [1:0]        mem_addr_lo;
  logic [REG_AW-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              mem_wren;
  logic              mem_flush;
  logic              dram_data_ok;
  logic [31:0]       dram_rdata;
  logic              wb_allowin;
  logic              mem_stall;
  logic              wb_valid;
  logic [31:0]       wb_inst;
  logic              wb_inslot;
  logic [REG_AW-1:0] wb_waddr;
  logic [31:0]       wb_wdata;
  logic              wb_wren;
  modport master (
    output mem_valid, mem_inst, mem_inslot, mem_memop, mem_addr_lo, mem_waddr, mem_wdata,
           mem_wren, mem_flush, dram_data_ok, dram_rdata, wb_allowin,
    input  mem_stall, wb_valid, wb_inst, wb_inslot, wb_waddr, wb_wdata, wb_wren
  );
  modport slave (
    input  mem_valid, mem_inst, mem_inslot, mem_memop, mem_addr_lo, mem_waddr, mem_wdata,
           mem_wren, mem_flush, dram_data_ok, dram_rdata, wb_allowin,
    output mem_stall, wb_valid, wb_inst, wb_inslot, wb_waddr, wb_wdata, wb_wren
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM-to-WB register with SRAM response wait, load alignment and flush-safe discard
//   ports: clk, rst_n (async active-low), bus (mem_wb_stage_if.slave: MEM slot in, SRAM response in,
//          wb_allowin in, mem_stall out, registered wb_* out)
//   MEM_WB_LWLR_EN: when defined, LWL/LWR are memory ops merging SRAM data with the old rt value
module mem_wb_stage #(
  parameter int REG_AW = 5,
  parameter int MMOP_W = 4
) (
  input logic clk,
  input logic rst_n,
  mem_wb_stage_if.slave bus
);
  localparam logic [MMOP_W-1:0] OP_LB = 1, OP_LBU = 2, OP_LH = 3, OP_LHU = 4, OP_LW = 5;
  localparam logic [MMOP_W-1:0] OP_SW = 8, OP_LWL = 9, OP_LWR = 10;
  typedef enum logic [1:0] {IDLE, WAIT, BUF, DISCARD} state_t;
  state_t state, state_nx;
  logic [31:0] rbuf, ld, res, rt;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic [REG_AW-1:0] waddr_q;
  logic is_mem, ready, accept, live, xfer, ok;
  wire [MMOP_W-1:0] op = bus.mem_memop;
  wire [1:0] a = bus.mem_addr_lo;
`ifdef MEM_WB_LWLR_EN
  assign is_mem = op >= OP_LB && op <= OP_LWR;
`else
  assign is_mem = op >= OP_LB && op <= OP_SW;
`endif
  assign ok = bus.dram_data_ok;
  // the orphaned response of a flushed op must never satisfy a new memory op
  assign ready = !is_mem || (state != DISCARD && (ok || state == BUF));
  assign accept = !bus.wb_valid || bus.wb_allowin;
  assign live = bus.mem_valid && !bus.mem_flush;
  assign xfer = live && ready && accept;
  assign bus.mem_stall = live && !(ready && accept);
  assign ld = state == BUF ? rbuf : bus.dram_rdata;
  assign ld_b = ld[{a, 3'b000} +: 8];
  assign ld_h = a[1] ? ld[31:16] : ld[15:0];
  assign rt = bus.mem_wdata;
  assign bus.wb_waddr = waddr_q;
  always_comb begin
    res = rt;
    case (op)
      OP_LB:   res = {{24{ld_b[7]}}, ld_b};
      OP_LBU:  res = {24'h0, ld_b};
      OP_LH:   res = {{16{ld_h[15]}}, ld_h};
      OP_LHU:  res = {16'h0, ld_h};
      OP_LW:   res = ld;
`ifdef MEM_WB_LWLR_EN
      OP_LWL:  res = a == 2'd0 ? {ld[7:0], rt[23:0]} : a == 2'd1 ? {ld[15:0], rt[15:0]} :
                     a == 2'd2 ? {ld[23:0], rt[7:0]} : ld;
      OP_LWR:  res = a == 2'd0 ? ld : a == 2'd1 ? {rt[31:24], ld[31:8]} :
                     a == 2'd2 ? {rt[31:16], ld[31:16]} : {rt[31:8], ld[31:24]};
`endif
      default: res = rt;
    endcase
  end
  // a same-cycle response that cannot leave is buffered; a flush always beats a response
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = live && is_mem ? (!ok ? WAIT : !accept ? BUF : IDLE) : IDLE;
      WAIT:    state_nx = bus.mem_flush ? (ok ? IDLE : DISCARD) : ok ? (accept ? IDLE : BUF) : WAIT;
      BUF:     state_nx = bus.mem_flush || xfer ? IDLE : BUF;
      DISCARD: state_nx = ok ? IDLE : DISCARD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rbuf <= '0;
    end else begin
      state <= state_nx;
      if (state_nx == BUF && state != BUF) rbuf <= bus.dram_rdata;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_valid <= 1'b0;
      bus.wb_inst <= '0;
      bus.wb_inslot <= 1'b0;
      waddr_q <= '0;
      bus.wb_wdata <= '0;
      bus.wb_wren <= 1'b0;
    end else if (xfer) begin
      bus.wb_valid <= 1'b1;
      bus.wb_inst <= bus.mem_inst;
      bus.wb_inslot <= bus.mem_inslot;
      waddr_q <= bus.mem_waddr;
      bus.wb_wdata <= res;
      bus.wb_wren <= bus.mem_wren;
    end else if (bus.wb_allowin) begin
      bus.wb_valid <= 1'b0;
    end
  end
endmodule
